avg_fetch: RTL and testbench
============================

# avg_fetch

Instruction fetch sequencer for the AVG, sitting directly upstream of `avg_decode`. It owns the program counter and the subroutine return stack. It reads four bytes of vector memory per instruction and presents the assembled 32-bit word to the decoder. It then advances, jumps, calls, returns or halts according to the decoder's control outputs once the downstream draw engine accepts the instruction.

## Interface
Parameters:
- `STACK_DEPTH`, 4: return-stack entries (power of two, ≥2).

Ports:
- `clk` input 1: the single clock.
- `rst` input 1: asynchronous, active-high reset.
- `go` input 1: start pulse; honored only while halted.
- `mem_addr` output 16: byte address to vector memory.
- `mem_rd_en` output 1: read strobe; memory returns `mem_data` one cycle later.
- `mem_data` input 8: read data.
- `inst` output 32: assembled instruction, to `avg_decode`.
- `inst_valid` output 1: `inst` is valid and stable.
- `inst_ready` input 1: downstream has consumed the current instruction.
- `pcOffset` input 3: from decoder.
- `jmp` input 1: from decoder.
- `jsr` input 1: from decoder.
- `ret` input 1: from decoder.
- `halt` input 1: from decoder.
- `jumpAddr` input 16: from decoder.
- `pc` output 16: current instruction byte address.
- `halted` output 1: sequencer idle; CPU-readable status.
- `stack_err` output 1: sticky flag for overflow or underflow; cleared by `go`.

## Operation
- Byte packing: byte at `pc+0` goes to `inst[31:24]`, `pc+1` to `[23:16]`, `pc+2` to `[15:8]`, and `pc+3` to `[7:0]`. All four bytes are always fetched, even for 2-byte opcodes.
- Address arithmetic is 16-bit and wraps modulo 2^16. The byte at 0xFFFF is followed by the byte at 0x0000.
- The state machine has three states: IDLE, FETCH and PRESENT.
- IDLE:
  - `halted`=1.
  - When `go`=1: `pc`←0, stack pointer←0, `stack_err`←0, then go to FETCH with counter `k`←0.
- FETCH (`k` = 0..4):
  - For `k`<4: `mem_rd_en`=1 and `mem_addr`=`pc+k`.
  - For `k`≥1: capture `mem_data` into byte `k-1`.
  - At `k`=4, go to PRESENT.
- PRESENT:
  - `inst_valid`=1; `inst` holds steady until the handshake.
  - The handshake is `inst_valid && inst_ready`. Decoder inputs are sampled only in that cycle.
- Handshake action, first match wins:
  1. `halt`: go to IDLE; `pc` unchanged.
  2. `ret`: if the stack is empty, set `stack_err` and go to IDLE. Otherwise pop into `pc` and go to FETCH.
  3. `jsr`: if the stack is full, set `stack_err` and go to IDLE. Otherwise push `pc+pcOffset`, set `pc`←`jumpAddr`, and go to FETCH.
  4. `jmp`: `pc`←`jumpAddr`, go to FETCH.
  5. Otherwise: `pc`←`pc+pcOffset`, go to FETCH.
- `pcOffset`=0 with no flow control re-fetches the same address. This is legal and is not an error.
- `go` outside IDLE is ignored.

## Timing
- Reset values:
  - `pc`=0, stack pointer=0.
  - `inst`=0, `inst_valid`=0.
  - `mem_rd_en`=0, `mem_addr`=0.
  - `halted`=1, `stack_err`=0.
  - State=IDLE.
- Asserting `rst` mid-fetch or mid-present drops `inst_valid` immediately (asynchronously); no handshake completes.
- Latency:
  - `go` sampled in cycle t gives first `mem_rd_en` at t+1 and `inst_valid` at t+6.
  - A handshake in cycle h gives the next `inst_valid` at h+6, so the minimum throughput is 1 instruction per 6 cycles.
- `inst_valid` deasserts in the cycle after the handshake.
- `halted` rises in the cycle after a halting handshake and falls in the cycle after `go`.
- `mem_rd_en` and `mem_addr` are registered outputs.
- `inst_valid`, `halted` and `pc` are registered.

## Structure
- `avg_pkg` holds:
  - the state enum (`AVG_IDLE`, `AVG_FETCH`, `AVG_PRESENT`);
  - `AVG_ADDR_W`=16;
  - `AVG_INST_BYTES`=4.
- Opcode encodings remain in `avg_defines.vh`.
- Sub-module `avg_ret_stack`:
  - LIFO of 16-bit entries, depth `STACK_DEPTH`.
  - Ports: `push`, `pop`, `din`, `dout`, `full`, `empty`, `clr`.
  - Same `clk`/`rst`.
  - Push when full and pop when empty are ignored internally; the error is flagged by `avg_fetch`.

## Test plan
- Memory bytes 0..3 = 12 34 56 78, `go` at t, decoder outputs forced to `pcOffset`=2 and no flow control → `mem_addr` 0,1,2,3 at t+1..t+4; `inst`=0x12345678 with `inst_valid` at t+6; after an immediate `inst_ready`, next fetch starts at address 2.
- `jsr` with `jumpAddr`=0x0100 at `pc`=0x0010, `pcOffset`=2 → fetch at 0x0100; a later `ret` → fetch at 0x0012.
- Five nested `jsr` with `STACK_DEPTH`=4 → `stack_err`=1 and `halted`=1 after the 5th; a following `go` clears `stack_err` and `pc`=0.
- `ret` from an empty stack → `stack_err`=1 and `halted`=1; no memory read is issued afterward.
- `inst_ready` held low for 10 cycles in PRESENT → `inst` stable and `mem_rd_en`=0 throughout; `pc` advances by `pcOffset` only after `inst_ready` rises.
- `pc`=0xFFFE fetch → `mem_addr` FFFE, FFFF, 0000, 0001; `rst` pulsed at fetch byte 2 → all outputs return to reset values immediately.

Source files
------------

// File: rtl/avg_pkg.sv
// Shared types and constants for the AVG instruction fetch path.
package avg_pkg;

  localparam int unsigned AVG_ADDR_W     = 16;
  localparam int unsigned AVG_INST_BYTES = 4;

  typedef enum logic [1:0] {
    AVG_IDLE,
    AVG_FETCH,
    AVG_PRESENT
  } avg_state_e;

endpackage

// File: rtl/avg_ret_stack.sv
// Subroutine return-address LIFO; overflow/underflow requests are dropped
// here and reported by the fetch sequencer.
module avg_ret_stack
  import avg_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [AVG_ADDR_W-1:0] din,
  output logic [AVG_ADDR_W-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned PW = $clog2(STACK_DEPTH);

  logic [PW:0]            sp;
  logic [AVG_ADDR_W-1:0]  entries [STACK_DEPTH];
  logic [PW-1:0]          top_idx;

  assign full    = (sp == (PW+1)'(STACK_DEPTH));
  assign empty   = (sp == '0);
  assign top_idx = sp[PW-1:0] - PW'(1);
  assign dout    = entries[top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (clr) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + (PW+1)'(1);
    end else if (pop && !empty) begin
      sp <= sp - (PW+1)'(1);
    end
  end

  // Storage needs no reset: nothing is readable until it has been pushed.
  always_ff @(posedge clk) begin
    if (push && !full && !clr) begin
      entries[sp[PW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/avg_fetch.sv
// AVG instruction fetch sequencer: reads four bytes per instruction, presents
// the word to the decoder and applies flow control on the handshake.
module avg_fetch
  import avg_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  output logic [AVG_ADDR_W-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [7:0]            mem_data,
  output logic [31:0]           inst,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  input  logic [2:0]            pcOffset,
  input  logic                  jmp,
  input  logic                  jsr,
  input  logic                  ret,
  input  logic                  halt,
  input  logic [AVG_ADDR_W-1:0] jumpAddr,
  output logic [AVG_ADDR_W-1:0] pc,
  output logic                  halted,
  output logic                  stack_err
);

  avg_state_e            state;
  logic [2:0]            k;
  logic [23:0]           byte_sr;

  logic                  hs;
  logic                  refetch;
  logic                  flow_err;
  logic [AVG_ADDR_W-1:0] seq_pc;
  logic [AVG_ADDR_W-1:0] target;

  logic                  stk_clr;
  logic                  stk_push;
  logic                  stk_pop;
  logic [AVG_ADDR_W-1:0] stk_dout;
  logic                  stk_full;
  logic                  stk_empty;

  avg_ret_stack #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_ret_stack (
    .clk  (clk),
    .rst  (rst),
    .clr  (stk_clr),
    .push (stk_push),
    .pop  (stk_pop),
    .din  (seq_pc),
    .dout (stk_dout),
    .full (stk_full),
    .empty(stk_empty)
  );

  // Handshake decode, first match wins: halt, ret, jsr, jmp, sequential.
  always_comb begin
    seq_pc   = pc + AVG_ADDR_W'(pcOffset);
    hs       = (state == AVG_PRESENT) && inst_valid && inst_ready;
    stk_clr  = (state == AVG_IDLE) && go;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    flow_err = 1'b0;
    refetch  = 1'b0;
    target   = seq_pc;
    if (hs) begin
      if (halt) begin
        refetch = 1'b0;
      end else if (ret) begin
        if (stk_empty) begin
          flow_err = 1'b1;
        end else begin
          stk_pop = 1'b1;
          refetch = 1'b1;
          target  = stk_dout;
        end
      end else if (jsr) begin
        if (stk_full) begin
          flow_err = 1'b1;
        end else begin
          stk_push = 1'b1;
          refetch  = 1'b1;
          target   = jumpAddr;
        end
      end else if (jmp) begin
        refetch = 1'b1;
        target  = jumpAddr;
      end else begin
        refetch = 1'b1;
      end
    end
  end

  // k tracks the cycle within FETCH; read data lags the address by one cycle,
  // so byte k-1 lands while address k is being issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= AVG_IDLE;
      k          <= '0;
      byte_sr    <= '0;
      pc         <= '0;
      inst       <= '0;
      inst_valid <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      halted     <= 1'b1;
      stack_err  <= 1'b0;
    end else begin
      case (state)
        AVG_IDLE: begin
          if (go) begin
            pc        <= '0;
            stack_err <= 1'b0;
            halted    <= 1'b0;
            k         <= '0;
            mem_rd_en <= 1'b1;
            mem_addr  <= '0;
            state     <= AVG_FETCH;
          end
        end

        AVG_FETCH: begin
          if (k == 3'(AVG_INST_BYTES)) begin
            inst       <= {byte_sr, mem_data};
            inst_valid <= 1'b1;
            mem_rd_en  <= 1'b0;
            state      <= AVG_PRESENT;
          end else begin
            if (k != '0) begin
              byte_sr <= {byte_sr[15:0], mem_data};
            end
            k <= k + 3'd1;
            if (k < 3'(AVG_INST_BYTES - 1)) begin
              mem_rd_en <= 1'b1;
              mem_addr  <= pc + AVG_ADDR_W'(k + 3'd1);
            end else begin
              mem_rd_en <= 1'b0;
            end
          end
        end

        AVG_PRESENT: begin
          if (hs) begin
            inst_valid <= 1'b0;
            if (refetch) begin
              pc        <= target;
              mem_addr  <= target;
              mem_rd_en <= 1'b1;
              k         <= '0;
              state     <= AVG_FETCH;
            end else begin
              halted <= 1'b1;
              state  <= AVG_IDLE;
              if (flow_err) begin
                stack_err <= 1'b1;
              end
            end
          end
        end

        default: begin
          state <= AVG_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avg_fetch.sv
// Directed bench for avg_fetch with a one-cycle-latency byte memory model.
module tb_avg_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_data = '0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [2:0]  pcOffset = 3'd2;
  logic        jmp = 1'b0;
  logic        jsr = 1'b0;
  logic        ret = 1'b0;
  logic        halt = 1'b0;
  logic [15:0] jumpAddr = '0;
  logic [15:0] pc;
  logic        halted;
  logic        stack_err;

  logic [7:0]  mem [65536];

  int errors = 0;
  int checks = 0;

  avg_fetch #(
    .STACK_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_data  (mem_data),
    .inst      (inst),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .pcOffset  (pcOffset),
    .jmp       (jmp),
    .jsr       (jsr),
    .ret       (ret),
    .halt      (halt),
    .jumpAddr  (jumpAddr),
    .pc        (pc),
    .halted    (halted),
    .stack_err (stack_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_data <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && inst_valid !== 1'b1; i++) tick();
    check(tag, {31'd0, inst_valid}, 32'd1);
  endtask

  task automatic handshake();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    jmp = 1'b0; jsr = 1'b0; ret = 1'b0; halt = 1'b0;
  endtask

  initial begin
    int bad;
    logic [31:0] held;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
    mem[16'hFFFE] = 8'hAA; mem[16'hFFFF] = 8'hBB;

    // Reset state
    tick(); tick();
    check("rst_halted", {31'd0, halted}, 32'd1);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_rden", {31'd0, mem_rd_en}, 32'd0);
    check("rst_pc", {16'd0, pc}, 32'd0);
    check("rst_inst", inst, 32'd0);
    rst = 1'b0;
    tick();

    // Basic fetch and packing
    go = 1'b1;
    tick();
    go = 1'b0;
    check("t1_rden", {31'd0, mem_rd_en}, 32'd1);
    check("t1_addr0", {16'd0, mem_addr}, 32'h0);
    check("t1_halted", {31'd0, halted}, 32'd0);
    tick(); check("t2_addr1", {16'd0, mem_addr}, 32'h1);
    tick(); check("t3_addr2", {16'd0, mem_addr}, 32'h2);
    tick(); check("t4_addr3", {16'd0, mem_addr}, 32'h3);
    tick();
    check("t5_rden", {31'd0, mem_rd_en}, 32'd0);
    check("t5_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    check("t6_valid", {31'd0, inst_valid}, 32'd1);
    check("t6_inst", inst, 32'h12345678);
    handshake();
    check("seq_valid_drop", {31'd0, inst_valid}, 32'd0);
    check("seq_pc", {16'd0, pc}, 32'h2);
    check("seq_addr", {16'd0, mem_addr}, 32'h2);
    check("seq_rden", {31'd0, mem_rd_en}, 32'd1);
    wait_valid("seq_wait");
    check("seq_inst", inst, 32'h56780000);

    // jmp, jsr, ret
    jmp = 1'b1; jumpAddr = 16'h0010;
    handshake();
    check("jmp_pc", {16'd0, pc}, 32'h0010);
    wait_valid("jmp_wait");
    jsr = 1'b1; jumpAddr = 16'h0100; pcOffset = 3'd2;
    handshake();
    check("jsr_addr", {16'd0, mem_addr}, 32'h0100);
    wait_valid("jsr_wait");
    ret = 1'b1;
    handshake();
    check("ret_pc", {16'd0, pc}, 32'h0012);
    check("ret_addr", {16'd0, mem_addr}, 32'h0012);

    // ret on empty stack
    wait_valid("uf_wait");
    ret = 1'b1;
    handshake();
    check("uf_err", {31'd0, stack_err}, 32'd1);
    check("uf_halted", {31'd0, halted}, 32'd1);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_rd_en !== 1'b0) bad++;
      tick();
    end
    check("uf_no_read", bad, 0);

    // Five nested jsr overflow a 4-deep stack
    go = 1'b1;
    tick();
    go = 1'b0;
    check("go_clr_err", {31'd0, stack_err}, 32'd0);
    check("go_pc", {16'd0, pc}, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      wait_valid("of_wait");
      jsr = 1'b1; jumpAddr = 16'(i * 16'h40);
      handshake();
      if (i == 4) check("of_pc4", {16'd0, pc}, 32'h0100);
    end
    check("of_err", {31'd0, stack_err}, 32'd1);
    check("of_halted", {31'd0, halted}, 32'd1);
    check("of_pc_hold", {16'd0, pc}, 32'h0100);
    go = 1'b1;
    tick();
    go = 1'b0;
    check("of_go_err", {31'd0, stack_err}, 32'd0);
    check("of_go_pc", {16'd0, pc}, 32'h0);

    // Back-pressure hold
    wait_valid("stall_wait");
    held = inst;
    check("stall_inst", held, 32'h12345678);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (inst !== held || mem_rd_en !== 1'b0 || inst_valid !== 1'b1 || pc !== 16'h0) bad++;
    end
    check("stall_stable", bad, 0);
    pcOffset = 3'd3;
    handshake();
    check("stall_pc", {16'd0, pc}, 32'h3);

    // Address wrap and asynchronous reset mid-fetch
    wait_valid("wrap_wait");
    jmp = 1'b1; jumpAddr = 16'hFFFE;
    handshake();
    check("wrap_a0", {16'd0, mem_addr}, 32'hFFFE);
    tick(); check("wrap_a1", {16'd0, mem_addr}, 32'hFFFF);
    tick(); check("wrap_a2", {16'd0, mem_addr}, 32'h0000);
    tick(); check("wrap_a3", {16'd0, mem_addr}, 32'h0001);
    wait_valid("wrap_valid");
    check("wrap_inst", inst, 32'hAABB1234);
    pcOffset = 3'd0;
    handshake();
    check("refetch_pc", {16'd0, pc}, 32'hFFFE);
    tick(); tick();
    check("prerst_addr", {16'd0, mem_addr}, 32'h0000);
    #2 rst = 1'b1;
    #1;
    check("arst_rden", {31'd0, mem_rd_en}, 32'd0);
    check("arst_addr", {16'd0, mem_addr}, 32'h0);
    check("arst_pc", {16'd0, pc}, 32'h0);
    check("arst_halted", {31'd0, halted}, 32'd1);
    check("arst_inst", inst, 32'h0);
    check("arst_valid", {31'd0, inst_valid}, 32'd0);
    rst = 1'b0;
    tick(); tick();
    check("post_rst_idle", {31'd0, mem_rd_en}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
